// File: rtl/mcycle_seq.sv
// Multi-cycle MIPS-style instruction sequencer: fetch/decode/exec/mem/writeback control,
// PC update, retired-instruction counter and bus-timeout detection.
module mcycle_seq #(
  parameter int unsigned PC_W     = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  input  logic             alu_zero,
  input  logic [31:0]      rs_val,
  output logic [31:0]      ir,
  output logic [PC_W-1:0]  pc,
  output logic             rf_we,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired,
  output logic             bus_err
);

  localparam int unsigned     WAIT_W  = 8;
  localparam logic [PC_W-1:0] RST_PC  = RESET_PC[PC_W-1:0];
  localparam logic [PC_W-1:0] HI_MASK = ~PC_W'(32'h0FFF_FFFF);
  localparam logic [WAIT_W-1:0] TMO   = WAIT_W'(TIMEOUT);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_BRK   = 6'h0D;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_ERR    = 3'd6
  } state_e;

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [31:0]        ir_q, ir_d;
  logic [CNT_W-1:0]   ret_q, ret_d;
  logic               err_q, err_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               imem_req_q, imem_req_d;
  logic               dmem_req_q, dmem_req_d;
  logic               dmem_we_q, dmem_we_d;
  logic               rf_we_q, rf_we_d;

  logic [5:0]         op, funct;
  logic [PC_W-1:0]    pc_plus4, pc_branch, pc_jump;
  logic [WAIT_W-1:0]  wait_inc;
  logic               retire;

  assign op        = ir_q[31:26];
  assign funct     = ir_q[5:0];
  assign pc_plus4  = pc_q + PC_W'(4);
  assign pc_branch = pc_plus4 + PC_W'({{14{ir_q[15]}}, ir_q[15:0], 2'b00});
  assign pc_jump   = (pc_plus4 & HI_MASK) | PC_W'({ir_q[25:0], 2'b00});
  assign wait_inc  = wait_q + WAIT_W'(1);

  // Next-state, datapath-register and registered-output computation
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    ret_d   = ret_q;
    err_d   = err_q;
    wait_d  = wait_q;
    retire  = 1'b0;

    case (state_q)
      S_FETCH: begin
        // The first FETCH cycle after reset has no request out yet, so acks are ignored
        if (imem_req_q) begin
          if (imem_ack) begin
            ir_d    = imem_rdata;
            state_d = S_DECODE;
          end else if (wait_inc >= TMO) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            wait_d = wait_inc;
          end
        end
      end
      S_DECODE: begin
        if (op == OP_RTYPE && funct == FN_BRK) state_d = S_HALT;
        else                                   state_d = S_EXEC;
      end
      S_EXEC: begin
        case (op)
          OP_BEQ, OP_BNE: begin
            pc_d    = ((op == OP_BEQ) == alu_zero) ? pc_branch : pc_plus4;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          OP_J: begin
            pc_d    = pc_jump;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          OP_JAL: begin
            pc_d    = pc_jump;
            state_d = S_WB;
          end
          OP_LW, OP_SW: state_d = S_MEM;
          OP_RTYPE: begin
            if (funct == FN_JR) begin
              pc_d    = rs_val[PC_W-1:0];
              retire  = 1'b1;
              state_d = S_FETCH;
            end else begin
              state_d = S_WB;
            end
          end
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (dmem_ack) begin
          if (op == OP_SW) begin
            pc_d    = pc_plus4;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_inc >= TMO) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_inc;
        end
      end
      S_WB: begin
        if (op != OP_JAL) pc_d = pc_plus4;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT, S_ERR: ;
      default: state_d = S_ERR;
    endcase

    if (retire) ret_d = ret_q + CNT_W'(1);
    if ((state_d == S_FETCH || state_d == S_MEM) && state_d != state_q) wait_d = '0;

    imem_req_d = (state_d == S_FETCH);
    dmem_req_d = (state_d == S_MEM);
    dmem_we_d  = (state_d == S_MEM) && (op == OP_SW);
    rf_we_d    = (state_d == S_WB);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_FETCH;
      pc_q       <= RST_PC;
      ir_q       <= '0;
      ret_q      <= '0;
      err_q      <= 1'b0;
      wait_q     <= '0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      rf_we_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ret_q      <= ret_d;
      err_q      <= err_d;
      wait_q     <= wait_d;
      imem_req_q <= imem_req_d;
      dmem_req_q <= dmem_req_d;
      dmem_we_q  <= dmem_we_d;
      rf_we_q    <= rf_we_d;
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = pc_q;
  assign dmem_req  = dmem_req_q;
  assign dmem_we   = dmem_we_q;
  assign ir        = ir_q;
  assign pc        = pc_q;
  assign rf_we     = rf_we_q;
  assign state     = state_q;
  assign retired   = ret_q;
  assign bus_err   = err_q;

endmodule

// File: tb/tb_mcycle_seq.sv
// Bench for mcycle_seq: directed vector table, corner-case sequences, and random
// instructions checked against an instruction-level reference model.
module tb_mcycle_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic        reset, imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, alu_zero, rf_we, bus_err;
  logic [31:0] imem_addr, imem_rdata, rs_val, ir, pc;
  logic [2:0]  state;
  logic [15:0] retired;

  // Narrow instance: 28-bit PC near the top of the space, 2-bit counter
  logic        reset_w, imem_req_w, imem_ack_w, dmem_req_w, dmem_we_w, dmem_ack_w, alu_zero_w, rf_we_w, bus_err_w;
  logic [27:0] imem_addr_w, pc_w;
  logic [31:0] imem_rdata_w, rs_val_w, ir_w;
  logic [2:0]  state_w;
  logic [1:0]  retired_w;

  mcycle_seq dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .alu_zero(alu_zero), .rs_val(rs_val), .ir(ir), .pc(pc), .rf_we(rf_we), .state(state),
    .retired(retired), .bus_err(bus_err)
  );

  mcycle_seq #(.PC_W(28), .RESET_PC(32'h0FFF_FFFC), .CNT_W(2), .TIMEOUT(15)) dut_w (
    .clk(clk), .reset(reset_w), .imem_req(imem_req_w), .imem_addr(imem_addr_w), .imem_ack(imem_ack_w),
    .imem_rdata(imem_rdata_w), .dmem_req(dmem_req_w), .dmem_we(dmem_we_w), .dmem_ack(dmem_ack_w),
    .alu_zero(alu_zero_w), .rs_val(rs_val_w), .ir(ir_w), .pc(pc_w), .rf_we(rf_we_w), .state(state_w),
    .retired(retired_w), .bus_err(bus_err_w)
  );

  typedef struct {
    logic [31:0] instr;
    int          wi;
    int          wd;
    logic        az;
    logic [31:0] rs;
    logic [31:0] exp_pc;
    int          exp_lat;
    int          exp_rf;
    int          exp_dreq;
    int          exp_dwe;
  } vec_t;

  localparam logic [31:0] ADDI = 32'h2008_0005;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] m_pc;
  int          m_ret;
  vec_t        tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Instruction-level reference: outcome of one instruction from the ISA rules
  function automatic vec_t model(logic [31:0] cur_pc, logic [31:0] instr, int wi, int wd,
                                 logic az, logic [31:0] rs);
    vec_t        v;
    logic [5:0]  op   = instr[31:26];
    logic [5:0]  fn   = instr[5:0];
    logic [31:0] seq  = cur_pc + 32'd4;
    logic [31:0] off  = 32'(int'($signed(instr[15:0])) * 4);
    logic [31:0] jtgt = (seq & 32'hF000_0000) + 32'({instr[25:0], 2'b00});
    logic        taken;
    v.instr = instr; v.wi = wi; v.wd = wd; v.az = az; v.rs = rs;
    v.exp_pc = seq; v.exp_lat = wi + 4; v.exp_rf = 1; v.exp_dreq = 0; v.exp_dwe = 0;
    if (op == 6'h04 || op == 6'h05) begin
      taken = (op == 6'h04) ? az : !az;
      if (taken) v.exp_pc = seq + off;
      v.exp_lat = wi + 3; v.exp_rf = 0;
    end else if (op == 6'h02) begin
      v.exp_pc = jtgt; v.exp_lat = wi + 3; v.exp_rf = 0;
    end else if (op == 6'h03) begin
      v.exp_pc = jtgt;
    end else if (op == 6'h00 && fn == 6'h08) begin
      v.exp_pc = rs; v.exp_lat = wi + 3; v.exp_rf = 0;
    end else if (op == 6'h23) begin
      v.exp_lat = wi + wd + 5; v.exp_dreq = wd + 1;
    end else if (op == 6'h2B) begin
      v.exp_lat = wi + wd + 4; v.exp_dreq = wd + 1; v.exp_dwe = wd + 1; v.exp_rf = 0;
    end
    return v;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r = $urandom;
    case ($urandom_range(0, 9))
      0:       return {6'h08, r[25:0]};
      1:       return {6'h00, r[25:6], 6'h20};
      2:       return {6'h04, r[25:0]};
      3:       return {6'h05, r[25:0]};
      4:       return {6'h02, r[25:0]};
      5:       return {6'h03, r[25:0]};
      6:       return {6'h00, r[25:6], 6'h08};
      7:       return {6'h23, r[25:0]};
      8:       return {6'h2B, r[25:0]};
      default: return {6'h0F, r[25:0]};
    endcase
  endfunction

  // Runs one instruction from the first FETCH request cycle to the next FETCH entry
  task automatic run_instr(input vec_t v, input string tag);
    int lat = 0, rf = 0, dreq = 0, dwe = 0;
    bit done = 0;
    chk({tag, "_addr"}, imem_addr, m_pc);
    for (int k = 0; k < v.wi; k++) begin
      imem_ack = 1'b0; dmem_ack = 1'($urandom_range(0, 1));
      cyc(); lat++;
    end
    imem_ack = 1'b1; imem_rdata = v.instr; alu_zero = v.az; rs_val = v.rs; dmem_ack = 1'b0;
    cyc(); lat++;
    chk({tag, "_decode"}, 32'(state), 32'd1);
    for (int k = 0; k < 40 && !done; k++) begin
      if (state == 3'd0) begin
        done = 1;
      end else begin
        if (rf_we) rf++;
        if (dmem_req) begin
          dreq++;
          if (dmem_we) dwe++;
        end
        dmem_ack = dmem_req ? (dreq == v.wd + 1) : 1'($urandom_range(0, 1));
        imem_ack = 1'($urandom_range(0, 1)); imem_rdata = $urandom;
        cyc(); lat++;
      end
    end
    imem_ack = 1'b0; dmem_ack = 1'b0;
    m_ret++;
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_latency"}, 32'(lat), 32'(v.exp_lat));
    chk({tag, "_pc"}, pc, v.exp_pc);
    chk({tag, "_rf_we"}, 32'(rf), 32'(v.exp_rf));
    chk({tag, "_dmem_req"}, 32'(dreq), 32'(v.exp_dreq));
    chk({tag, "_dmem_we"}, 32'(dwe), 32'(v.exp_dwe));
    chk({tag, "_retired"}, 32'(retired), 32'(16'(m_ret)));
    chk({tag, "_ireq"}, 32'(imem_req), 32'd1);
    m_pc = v.exp_pc;
  endtask

  task automatic do_reset();
    reset = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    cyc(); cyc();
    m_pc = 32'h0; m_ret = 0;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_ir", ir, 32'h0);
    chk("rst_retired", 32'(retired), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_reqs", {28'h0, imem_req, dmem_req, dmem_we, rf_we}, 32'h0);
  endtask

  // Releases reset with a spurious ack that must be ignored before the request is out
  task automatic do_release();
    imem_ack = 1'b1; imem_rdata = ADDI; reset = 1'b1;
    cyc();
    imem_ack = 1'b0;
    chk("rel_ireq", 32'(imem_req), 32'd1);
    chk("rel_state", 32'(state), 32'd0);
    chk("rel_ir", ir, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n = 0, cnt = 0;
    logic [1:0] last;
    vec_t v;

    reset = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0; dmem_ack = 1'b0; alu_zero = 1'b0; rs_val = 32'h0;
    reset_w = 1'b0; imem_ack_w = 1'b1; imem_rdata_w = ADDI; dmem_ack_w = 1'b1; alu_zero_w = 1'b0; rs_val_w = 32'h0;

    // Narrow instance: PC wraps modulo 2^28, counter wraps modulo 4
    cyc(); cyc();
    chk("w_rst_pc", 32'(pc_w), 32'h0FFF_FFFC);
    reset_w = 1'b1; last = retired_w;
    for (int k = 0; k < 100 && n < 4; k++) begin
      cyc();
      if (retired_w != last) begin
        n++; last = retired_w;
        if (n == 1) chk("w_pc_wrap", 32'(pc_w), 32'h0);
        if (n == 4) begin
          chk("w_ret_wrap", 32'(retired_w), 32'd0);
          chk("w_pc_4", 32'(pc_w), 32'hC);
        end
      end
    end
    chk("w_retires", 32'(n), 32'd4);
    reset_w = 1'b0;

    // Directed vector table, run back to back from reset
    tbl[0]  = '{ADDI,          0, 0, 1'b0, 32'h0,         32'h0000_0004, 4, 1, 0, 0};
    tbl[1]  = '{ADDI,          0, 0, 1'b0, 32'h0,         32'h0000_0008, 4, 1, 0, 0};
    tbl[2]  = '{32'h1000_FFFE, 0, 0, 1'b1, 32'h0,         32'h0000_0004, 3, 0, 0, 0};
    tbl[3]  = '{ADDI,          0, 0, 1'b0, 32'h0,         32'h0000_0008, 4, 1, 0, 0};
    tbl[4]  = '{32'h1000_FFFE, 0, 0, 1'b0, 32'h0,         32'h0000_000C, 3, 0, 0, 0};
    tbl[5]  = '{32'h8C09_0000, 0, 3, 1'b0, 32'h0,         32'h0000_0010, 8, 1, 4, 0};
    tbl[6]  = '{32'hAC09_0004, 0, 0, 1'b0, 32'h0,         32'h0000_0014, 4, 0, 1, 1};
    tbl[7]  = '{32'h0800_0010, 0, 0, 1'b0, 32'h0,         32'h0000_0040, 3, 0, 0, 0};
    tbl[8]  = '{32'h0C00_0020, 0, 0, 1'b0, 32'h0,         32'h0000_0080, 4, 1, 0, 0};
    tbl[9]  = '{32'h0320_0008, 0, 0, 1'b0, 32'h1234_5678, 32'h1234_5678, 3, 0, 0, 0};
    tbl[10] = '{32'h1420_0003, 0, 0, 1'b0, 32'h0,         32'h1234_5688, 3, 0, 0, 0};
    tbl[11] = '{ADDI,          2, 0, 1'b0, 32'h0,         32'h1234_568C, 6, 1, 0, 0};
    tbl[12] = '{32'h1420_0003, 0, 0, 1'b1, 32'h0,         32'h1234_5690, 3, 0, 0, 0};
    tbl[13] = '{32'hAC09_0000, 1, 2, 1'b0, 32'h0,         32'h1234_5694, 7, 0, 3, 3};
    do_reset();
    do_release();
    foreach (tbl[i]) run_instr(tbl[i], $sformatf("vec%0d", i));

    // break halts with pc/retired frozen; reset is asynchronous
    imem_ack = 1'b1; imem_rdata = 32'h0000_000D;
    cyc();
    imem_ack = 1'b0;
    chk("brk_decode", 32'(state), 32'd1);
    cyc();
    chk("brk_halt", 32'(state), 32'd5);
    for (int k = 0; k < 4; k++) begin
      imem_ack = 1'($urandom_range(0, 1)); dmem_ack = 1'b1;
      cyc();
      chk("halt_hold", {state, rf_we, imem_req, dmem_req, pc[23:0], retired[1:0]},
          {3'd5, 3'b000, m_pc[23:0], 2'(m_ret)});
    end
    chk("halt_pc", pc, m_pc);
    reset = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    #2;
    chk("async_state", 32'(state), 32'd0);
    chk("async_pc", pc, 32'h0);
    chk("async_ret", 32'(retired), 32'd0);

    // Random instruction stream against the reference model
    do_reset();
    do_release();
    for (int i = 0; i < 60; i++) begin
      v = model(m_pc, rand_instr(), $urandom_range(0, 3), $urandom_range(0, 4),
                1'($urandom_range(0, 1)), $urandom);
      run_instr(v, $sformatf("rnd%0d", i));
    end

    // Reset during a data access aborts it without retiring
    do_reset();
    do_release();
    run_instr(model(m_pc, ADDI, 0, 0, 1'b0, 32'h0), "pre_abort");
    imem_ack = 1'b1; imem_rdata = 32'h8C09_0000;
    cyc(); imem_ack = 1'b0;
    cyc(); cyc();
    chk("abort_in_mem", {state, dmem_req}, {3'd3, 1'b1});
    reset = 1'b0;
    #1;
    chk("abort_regs", {state, dmem_req, retired[1:0]}, {3'd0, 1'b0, 2'd0});

    // Data-side timeout: 15 unacknowledged request cycles then ERR
    do_reset();
    do_release();
    imem_ack = 1'b1; imem_rdata = 32'h8C09_0000;
    cyc(); imem_ack = 1'b0;
    cnt = 0;
    for (int k = 0; k < 40 && state != 3'd6; k++) begin
      if (dmem_req) cnt++;
      cyc();
    end
    chk("dto_cycles", 32'(cnt), 32'd15);
    chk("dto_err", {state, bus_err, dmem_req}, {3'd6, 1'b1, 1'b0});

    // Fetch timeout: no ack for 15 request cycles
    do_reset();
    do_release();
    repeat (14) cyc();
    chk("ito_wait14", {state, bus_err}, {3'd0, 1'b0});
    cyc();
    chk("ito_err", {state, bus_err, imem_req}, {3'd6, 1'b1, 1'b0});
    for (int k = 0; k < 3; k++) begin
      imem_ack = 1'b1;
      cyc();
      chk("err_hold", {state, bus_err, pc[27:0]}, {3'd6, 1'b1, 28'h0});
    end
    imem_ack = 1'b0;

    // Ack on the 15th request cycle wins over the timeout
    do_reset();
    do_release();
    repeat (14) cyc();
    imem_ack = 1'b1; imem_rdata = ADDI;
    cyc();
    imem_ack = 1'b0;
    chk("ack15_state", 32'(state), 32'd1);
    chk("ack15_err", 32'(bus_err), 32'd0);
    chk("ack15_ir", ir, ADDI);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mcycle_seq.md
MCYCLE_SEQ -- requirements
Module: mcycle_seq

Interface
REQ-001 SHALL have parameter PC_W, default 32, PC/instruction-address width, legal range 28..32.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value after reset, truncated to PC_W bits.
REQ-003 SHALL have parameter CNT_W, default 16, retired-instruction counter width.
REQ-004 SHALL have parameter TIMEOUT, default 15, maximum wait cycles per memory access, legal range 1..255.
REQ-005 SHALL have ports, in this order:
 clk  in  1  single clock, rising edge
 reset  in  1  asynchronous, active-low
 imem_req  out  1  instruction fetch request
 imem_addr  out  PC_W  fetch address (= pc)
 imem_ack  in  1  fetch data valid
 imem_rdata  in  32  fetched instruction
 dmem_req  out  1  data access request
 dmem_we  out  1  data write (sw)
 dmem_ack  in  1  data access complete
 alu_zero  in  1  ALU zero flag from datapath
 rs_val  in  32  register rs value (jr)
 ir  out  32  latched instruction
 pc  out  PC_W  program counter
 rf_we  out  1  register-file write strobe
 state  out  3  FSM state encoding
 retired  out  CNT_W  retired-instruction count
 bus_err  out  1  sticky timeout error

Function
REQ-006 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, ERR=6; state output = current encoding.
REQ-007 FETCH: SHALL assert imem_req until the imem_ack cycle; on ack, latch ir <= imem_rdata and go to DECODE.
REQ-008 DECODE: one cycle; SHALL go to HALT if ir[31:26]=0 and ir[5:0]=6'h0D (break), else to EXEC.
REQ-009 EXEC, beq (op 6'h04) / bne (op 6'h05): SHALL set pc <= pc+4+(sext(ir[15:0])<<2) when taken (beq: alu_zero=1; bne: alu_zero=0), else pc <= pc+4; retire; go to FETCH.
REQ-010 EXEC, j (op 6'h02): SHALL set pc <= {pc_plus4[PC_W-1:28], ir[25:0], 2'b00}; retire; go to FETCH.
REQ-011 EXEC, jal (op 6'h03): SHALL set pc as for j and go to WB, where no further pc update occurs.
REQ-012 EXEC, jr (op 0, funct 6'h08): SHALL set pc <= rs_val[PC_W-1:0]; retire; go to FETCH.
REQ-013 EXEC, lw (op 6'h23) / sw (op 6'h2B): SHALL go to MEM; all other opcodes go to WB.
REQ-014 MEM: SHALL assert dmem_req, and dmem_we=1 only for sw, until the dmem_ack cycle; on ack, sw sets pc <= pc+4, retires and goes to FETCH; lw goes to WB.
REQ-015 WB: SHALL assert rf_we for exactly one cycle, set pc <= pc+4 (except jal), retire, and go to FETCH.
REQ-016 "Retire" SHALL increment retired by 1, modulo 2^CNT_W; all pc arithmetic SHALL be modulo 2^PC_W.
REQ-017 A wait counter SHALL clear on entry to FETCH or MEM and increment each cycle the request is not acknowledged; on reaching TIMEOUT, go to ERR and set bus_err=1.
REQ-018 An ack in the same cycle the counter reaches TIMEOUT SHALL win: normal completion, no error.
REQ-019 imem_ack or dmem_ack outside its request state SHALL be ignored.
REQ-020 HALT and ERR SHALL be terminal until reset; all request and rf_we outputs are 0 there, and pc, ir and retired hold.
REQ-021 Latency, zero wait states: ALU op 4 cycles; branch/j/jr 3 cycles; sw 4 cycles; lw 5 cycles.

Reset
REQ-022 When reset=0, asynchronously: state=FETCH, pc=RESET_PC, ir=0, retired=0, bus_err=0, wait counter=0, imem_req/dmem_req/dmem_we/rf_we=0.
REQ-023 imem_req SHALL assert in the first cycle after reset deasserts; reset mid-access SHALL abort the access with no retire.

Verification
REQ-024 Reset, then fetch 32'h2008_0005 (addi) with immediate ack -> states 0,1,2,4, rf_we pulse in WB, pc=4, retired=1.
REQ-025 pc=8, beq 32'h1000_FFFE, alu_zero=1 -> pc=8+4-8=4; with alu_zero=0 -> pc=12.
REQ-026 lw 32'h8C09_0000, dmem_ack delayed 3 cycles -> dmem_req high 4 cycles, dmem_we=0, then WB, retired+1; sw -> dmem_we=1, no rf_we.
REQ-027 TIMEOUT=15, imem_ack held 0 -> state=ERR, bus_err=1 after 15 cycles; ack on exactly cycle 15 -> DECODE, bus_err=0.
REQ-028 Fetch break 32'h0000_000D -> HALT; pc and retired frozen; reset=0 -> pc=RESET_PC, state=FETCH.
REQ-029 PC_W=28, RESET_PC=28'hFFF_FFFC, addi -> pc wraps to 0; CNT_W=2, 4 retires -> retired=0.
